// File: rtl/counter_pkg.sv
// Shared definitions for the counter primitives of the Sequential_circuits library.
// Holds the direction encoding used on up_dn and a ceil-log2 helper that callers
// use to size WIDTH from a desired MODULUS.
package counter_pkg;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    // Smallest bit count able to hold the values 0..value-1 (at least 1).
    function automatic int clog2(input int value);
        int bits;
        int span;
        bits = 0;
        span = 1;
        while (span < value) begin
            span = span * 2;
            bits = bits + 1;
        end
        if (bits == 0) begin
            bits = 1;
        end
        return bits;
    endfunction

endpackage

// File: rtl/mod_updown_counter_bin2gray.sv
// Combinational binary-to-Gray encoder, WIDTH bits wide.
// Only instantiated when MOD_UPDOWN_COUNTER_GRAY_EN is defined.
module bin2gray #(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray
);

    // Adjacent-bit XOR gives the reflected Gray code.
    always_comb begin
        gray = bin ^ (bin >> 1);
    end

endmodule

// File: rtl/mod_updown_counter.sv
// Generic modulo up/down counter with count enable and synchronous load.
// Load values above MODULUS-1 are clamped to MODULUS-1. tc is a combinational
// terminal-count flag for cascading; wrap is a registered one-cycle pulse in the
// cycle after the count rolls over in either direction.
// Optional feature: define MOD_UPDOWN_COUNTER_GRAY_EN to add a registered Gray
// encoded copy of count on port gray.
module mod_updown_counter
    import counter_pkg::*;
#(
    parameter int WIDTH   = 3,
    parameter int MODULUS = 8,
    parameter int INIT    = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap
`ifdef MOD_UPDOWN_COUNTER_GRAY_EN
    ,
    output logic [WIDTH-1:0] gray
`endif
);

    // Compares run one bit wider so MODULUS = 2**WIDTH is representable.
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MODULUS - 1);
    localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] INIT_W  = WIDTH'(INIT);

    logic             at_max;
    logic             at_zero;
    logic [WIDTH-1:0] next_count;
    logic             next_wrap;

    // Boundary detection on the widened count.
    always_comb begin
        at_max  = ({1'b0, count} == MAX_EXT);
        at_zero = (count == '0);
    end

    // Terminal count: the next enabled step will roll over.
    always_comb begin
        tc = en & ((up_dn == DIR_UP) ? at_max : at_zero);
    end

    // Next-state selection with priority load > enable > hold.
    always_comb begin
        next_count = count;
        next_wrap  = 1'b0;
        if (load) begin
            if ({1'b0, load_val} < MOD_EXT) begin
                next_count = load_val;
            end else begin
                next_count = MAX_W;
            end
        end else if (en) begin
            if (up_dn == DIR_UP) begin
                if (at_max) begin
                    next_count = '0;
                    next_wrap  = 1'b1;
                end else begin
                    next_count = count + WIDTH'(1);
                end
            end else begin
                if (at_zero) begin
                    next_count = MAX_W;
                    next_wrap  = 1'b1;
                end else begin
                    next_count = count - WIDTH'(1);
                end
            end
        end
    end

    // Count and wrap registers; reset takes effect without a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= INIT_W;
            wrap  <= 1'b0;
        end else begin
            count <= next_count;
            wrap  <= next_wrap;
        end
    end

`ifdef MOD_UPDOWN_COUNTER_GRAY_EN
    localparam logic [WIDTH-1:0] INIT_GRAY = INIT_W ^ (INIT_W >> 1);

    logic [WIDTH-1:0] next_gray;

    bin2gray #(
        .WIDTH(WIDTH)
    ) u_bin2gray (
        .bin (next_count),
        .gray(next_gray)
    );

    // Gray register tracks count in the same cycle by encoding the next value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gray <= INIT_GRAY;
        end else begin
            gray <= next_gray;
        end
    end
`endif

endmodule

// File: tb/tb_mod_updown_counter.sv
// Self-checking bench for mod_updown_counter: directed scenarios plus randomized
// stimulus compared against an arithmetic reference model.
module tb_mod_updown_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // MODULUS=8 instance
    logic rst8, en8, up8, ld8, tc8, wr8;
    logic [2:0] lv8, cnt8;
    // MODULUS=6 instance
    logic rst6, en6, up6, ld6, tc6, wr6;
    logic [2:0] lv6, cnt6;
    // MODULUS=2, WIDTH=1 instance
    logic rst2, en2, up2, ld2, tc2, wr2;
    logic [0:0] lv2, cnt2;
    // cascade pair
    logic rstc, enc, tc_lo, tc_hi, wr_lo, wr_hi;
    logic [2:0] cnt_lo, cnt_hi;
`ifdef MOD_UPDOWN_COUNTER_GRAY_EN
    logic [2:0] g8, g6, g_lo, g_hi;
    logic [0:0] g2;
`endif

    mod_updown_counter #(.WIDTH(3), .MODULUS(8), .INIT(0)) dut8 (
        .clk(clk), .rst(rst8), .en(en8), .up_dn(up8), .load(ld8), .load_val(lv8),
        .count(cnt8), .tc(tc8), .wrap(wr8)
`ifdef MOD_UPDOWN_COUNTER_GRAY_EN
        , .gray(g8)
`endif
    );

    mod_updown_counter #(.WIDTH(3), .MODULUS(6), .INIT(0)) dut6 (
        .clk(clk), .rst(rst6), .en(en6), .up_dn(up6), .load(ld6), .load_val(lv6),
        .count(cnt6), .tc(tc6), .wrap(wr6)
`ifdef MOD_UPDOWN_COUNTER_GRAY_EN
        , .gray(g6)
`endif
    );

    mod_updown_counter #(.WIDTH(1), .MODULUS(2), .INIT(0)) dut2 (
        .clk(clk), .rst(rst2), .en(en2), .up_dn(up2), .load(ld2), .load_val(lv2),
        .count(cnt2), .tc(tc2), .wrap(wr2)
`ifdef MOD_UPDOWN_COUNTER_GRAY_EN
        , .gray(g2)
`endif
    );

    mod_updown_counter #(.WIDTH(3), .MODULUS(8), .INIT(0)) dut_lo (
        .clk(clk), .rst(rstc), .en(enc), .up_dn(1'b1), .load(1'b0), .load_val(3'd0),
        .count(cnt_lo), .tc(tc_lo), .wrap(wr_lo)
`ifdef MOD_UPDOWN_COUNTER_GRAY_EN
        , .gray(g_lo)
`endif
    );

    mod_updown_counter #(.WIDTH(3), .MODULUS(8), .INIT(0)) dut_hi (
        .clk(clk), .rst(rstc), .en(tc_lo), .up_dn(1'b1), .load(1'b0), .load_val(3'd0),
        .count(cnt_hi), .tc(tc_hi), .wrap(wr_hi)
`ifdef MOD_UPDOWN_COUNTER_GRAY_EN
        , .gray(g_hi)
`endif
    );

    // Reference model state
    int  m8, m6, m2;
    bit  w8, w6, w2;

    // Behavioural next state: clamp on load, else step and fold back into 0..m-1.
    function automatic void ref_next(input int m, input int cnt, input bit ld, input int lv,
                                     input bit en, input bit up, output int ncnt, output bit nwrap);
        int t;
        nwrap = 1'b0;
        if (ld) begin
            ncnt = (lv < m) ? lv : m - 1;
        end else if (en) begin
            t = cnt + (up ? 1 : -1);
            nwrap = (t < 0) || (t >= m);
            ncnt = (t + m) % m;
        end else begin
            ncnt = cnt;
        end
    endfunction

    function automatic bit ref_tc(input int m, input int cnt, input bit en, input bit up);
        return en && (up ? (cnt == m - 1) : (cnt == 0));
    endfunction

    task automatic test_reset();
        rst8 = 1; rst6 = 1; rst2 = 1; rstc = 1;
        en8 = 1; up8 = 1; ld8 = 0; lv8 = 0;
        en6 = 1; up6 = 1; ld6 = 0; lv6 = 0;
        en2 = 0; up2 = 1; ld2 = 0; lv2 = 0;
        enc = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (cnt8 !== 3'd0 || wr8 !== 1'b0) begin
            errors++; $display("FAIL reset8 count=%0d wrap=%0b expected 0/0", cnt8, wr8);
        end
        checks++;
        if (cnt6 !== 3'd0 || wr6 !== 1'b0 || cnt2 !== 1'b0 || wr2 !== 1'b0) begin
            errors++; $display("FAIL reset6_2 cnt6=%0d wr6=%0b cnt2=%0d wr2=%0b expected zeros", cnt6, wr6, cnt2, wr2);
        end
        checks++;
        if (cnt_lo !== 3'd0 || cnt_hi !== 3'd0 || wr_lo !== 1'b0) begin
            errors++; $display("FAIL reset_cascade lo=%0d hi=%0d expected 0/0", cnt_lo, cnt_hi);
        end
        m8 = 0; w8 = 0; m6 = 0; w6 = 0; m2 = 0; w2 = 0;
        en8 = 0; en6 = 0;
        rst8 = 0; rst6 = 0; rst2 = 0; rstc = 0;
    endtask

    task automatic test_up_count();
        int n; bit nw;
        en8 = 1; up8 = 1; ld8 = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            checks++;
            if (tc8 !== ref_tc(8, m8, 1'b1, 1'b1)) begin
                errors++; $display("FAIL up_tc step%0d tc=%0b expected %0b", i, tc8, ref_tc(8, m8, 1'b1, 1'b1));
            end
            ref_next(8, m8, 1'b0, 0, 1'b1, 1'b1, n, nw);
            @(posedge clk); #1;
            m8 = n; w8 = nw;
            checks++;
            if (cnt8 !== 3'(m8) || wr8 !== w8) begin
                errors++; $display("FAIL up_count step%0d count=%0d wrap=%0b expected %0d/%0b", i, cnt8, wr8, m8, w8);
            end
        end
        // after 10 steps from 0 the count must be 2 with wrap already cleared
        checks++;
        if (cnt8 !== 3'd2 || wr8 !== 1'b0) begin
            errors++; $display("FAIL up_final count=%0d wrap=%0b expected 2/0", cnt8, wr8);
        end
        en8 = 0;
    endtask

    task automatic test_down_mod6();
        int n; bit nw;
        en6 = 1; up6 = 0; ld6 = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            checks++;
            if (tc6 !== ref_tc(6, m6, 1'b1, 1'b0)) begin
                errors++; $display("FAIL down_tc step%0d tc=%0b expected %0b", i, tc6, ref_tc(6, m6, 1'b1, 1'b0));
            end
            ref_next(6, m6, 1'b0, 0, 1'b1, 1'b0, n, nw);
            @(posedge clk); #1;
            m6 = n; w6 = nw;
            checks++;
            if (cnt6 !== 3'(m6) || wr6 !== w6 || cnt6 > 3'd5) begin
                errors++; $display("FAIL down6 step%0d count=%0d wrap=%0b expected %0d/%0b", i, cnt6, wr6, m6, w6);
            end
        end
        en6 = 0;
    endtask

    task automatic test_load_clamp();
        // park at 0, then load an out-of-range value while a down-wrap is also requested
        ld6 = 1; lv6 = 3'd0; en6 = 0;
        @(posedge clk); #1;
        m6 = 0; w6 = 0;
        ld6 = 1; lv6 = 3'd7; en6 = 1; up6 = 0;
        @(posedge clk); #1;
        checks++;
        if (cnt6 !== 3'd5 || wr6 !== 1'b0) begin
            errors++; $display("FAIL load_clamp count=%0d wrap=%0b expected 5/0", cnt6, wr6);
        end
        lv6 = 3'd6; up6 = 1;
        @(posedge clk); #1;
        checks++;
        if (cnt6 !== 3'd5 || wr6 !== 1'b0) begin
            errors++; $display("FAIL load_clamp6 count=%0d wrap=%0b expected 5/0", cnt6, wr6);
        end
        lv6 = 3'd3;
        @(posedge clk); #1;
        checks++;
        if (cnt6 !== 3'd3) begin
            errors++; $display("FAIL load_inrange count=%0d expected 3", cnt6);
        end
        m6 = 3; w6 = 0;
        ld6 = 0; en6 = 0;
    endtask

    task automatic test_async_reset();
        rst8 = 1; #2; rst8 = 0;
        m8 = 0; w8 = 0;
        en8 = 1; up8 = 1; ld8 = 0;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (cnt8 !== 3'd4) begin
            errors++; $display("FAIL async_pre count=%0d expected 4", cnt8);
        end
        #2; rst8 = 1; #1;
        checks++;
        if (cnt8 !== 3'd0 || wr8 !== 1'b0) begin
            errors++; $display("FAIL async_immediate count=%0d wrap=%0b expected 0/0", cnt8, wr8);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (cnt8 !== 3'd0) begin
            errors++; $display("FAIL async_hold count=%0d expected 0", cnt8);
        end
        rst8 = 0;
        for (int i = 1; i <= 2; i++) begin
            @(posedge clk); #1;
            checks++;
            if (cnt8 !== 3'(i)) begin
                errors++; $display("FAIL async_resume step%0d count=%0d expected %0d", i, cnt8, i);
            end
        end
        m8 = 2; w8 = 0;
        en8 = 0;
    endtask

    task automatic test_cascade();
        int total;
`ifdef MOD_UPDOWN_COUNTER_GRAY_EN
        logic [2:0] prev_g;
`endif
        rstc = 1; #2; rstc = 0;
        total = 0;
        enc = 1;
        for (int i = 0; i < 70; i++) begin
`ifdef MOD_UPDOWN_COUNTER_GRAY_EN
            prev_g = g_lo;
`endif
            @(posedge clk); #1;
            total++;
            checks++;
            if (cnt_lo !== 3'(total % 8) || cnt_hi !== 3'((total / 8) % 8)) begin
                errors++; $display("FAIL cascade step%0d hi=%0d lo=%0d expected %0d/%0d",
                                   i, cnt_hi, cnt_lo, (total / 8) % 8, total % 8);
            end
`ifdef MOD_UPDOWN_COUNTER_GRAY_EN
            checks++;
            if ($countones(prev_g ^ g_lo) != 1 || g_lo !== (cnt_lo ^ (cnt_lo >> 1))) begin
                errors++; $display("FAIL gray_step step%0d gray=%0h prev=%0h count=%0d", i, g_lo, prev_g, cnt_lo);
            end
`endif
        end
        checks++;
        if ({cnt_hi, cnt_lo} !== 6'd6) begin
            errors++; $display("FAIL cascade_final value=%0d expected 6", {cnt_hi, cnt_lo});
        end
        enc = 0;
    endtask

    task automatic test_hold();
        ld8 = 1; lv8 = 3'd3; en8 = 1;
        @(posedge clk); #1;
        ld8 = 0; en8 = 0;
        for (int i = 0; i < 5; i++) begin
            up8 = i[0];
            #1;
            checks++;
            if (tc8 !== 1'b0) begin
                errors++; $display("FAIL hold_tc step%0d tc=%0b expected 0", i, tc8);
            end
            @(posedge clk); #1;
            checks++;
            if (cnt8 !== 3'd3 || wr8 !== 1'b0) begin
                errors++; $display("FAIL hold step%0d count=%0d wrap=%0b expected 3/0", i, cnt8, wr8);
            end
        end
        en8 = 1; up8 = 0;
        @(posedge clk); #1;
        checks++;
        if (cnt8 !== 3'd2) begin
            errors++; $display("FAIL hold_release count=%0d expected 2", cnt8);
        end
        m8 = 2; w8 = 0;
        en8 = 0;
    endtask

    task automatic test_random();
        int n8, n6, n2;
        bit nw8, nw6, nw2;
        for (int i = 0; i < 400; i++) begin
            ld8 = ($urandom_range(0, 7) == 0); lv8 = 3'($urandom_range(0, 7));
            en8 = $urandom_range(0, 1);       up8 = $urandom_range(0, 1);
            ld6 = ($urandom_range(0, 7) == 0); lv6 = 3'($urandom_range(0, 7));
            en6 = ($urandom_range(0, 3) != 0); up6 = $urandom_range(0, 1);
            ld2 = ($urandom_range(0, 7) == 0); lv2 = 1'($urandom_range(0, 1));
            en2 = ($urandom_range(0, 3) != 0); up2 = $urandom_range(0, 1);
            #1;
            checks++;
            if (tc8 !== ref_tc(8, m8, en8, up8) || tc6 !== ref_tc(6, m6, en6, up6) || tc2 !== ref_tc(2, m2, en2, up2)) begin
                errors++; $display("FAIL rand_tc step%0d tc8=%0b tc6=%0b tc2=%0b", i, tc8, tc6, tc2);
            end
            ref_next(8, m8, ld8, int'(lv8), en8, up8, n8, nw8);
            ref_next(6, m6, ld6, int'(lv6), en6, up6, n6, nw6);
            ref_next(2, m2, ld2, int'(lv2), en2, up2, n2, nw2);
            @(posedge clk); #1;
            m8 = n8; w8 = nw8; m6 = n6; w6 = nw6; m2 = n2; w2 = nw2;
            checks++;
            if (cnt8 !== 3'(m8) || wr8 !== w8) begin
                errors++; $display("FAIL rand8 step%0d count=%0d wrap=%0b expected %0d/%0b", i, cnt8, wr8, m8, w8);
            end
            checks++;
            if (cnt6 !== 3'(m6) || wr6 !== w6) begin
                errors++; $display("FAIL rand6 step%0d count=%0d wrap=%0b expected %0d/%0b", i, cnt6, wr6, m6, w6);
            end
            checks++;
            if (cnt2 !== 1'(m2) || wr2 !== w2) begin
                errors++; $display("FAIL rand2 step%0d count=%0d wrap=%0b expected %0d/%0b", i, cnt2, wr2, m2, w2);
            end
        end
        en8 = 0; en6 = 0; en2 = 0; ld8 = 0; ld6 = 0; ld2 = 0;
    endtask

    initial begin
        test_reset();
        test_up_count();
        test_down_mod6();
        test_load_clamp();
        test_async_reset();
        test_cascade();
        test_hold();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
